// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared types for the data memory block
//
// Purpose: access-size and controller-state enums shared by data_mem,
//          its lane extractor and the bench, plus the access-size helpers.
// Ports:   none (package).
package data_mem_pkg;

  // Access width of a load or store. The fourth encoding is illegal and faults.
  typedef enum logic [1:0] {
    BYTE      = 2'b00,
    HALF_WORD = 2'b01,
    WORD      = 2'b10
  } ram_size_e;

  // Request/response controller state.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } dmem_state_e;

  // True for the three legal access widths.
  function automatic logic size_legal(input ram_size_e size);
    return (size == BYTE) || (size == HALF_WORD) || (size == WORD);
  endfunction

  // True when the access is not naturally aligned for its width.
  function automatic logic size_misaligned(input ram_size_e size, input logic [1:0] offset);
    return ((size == HALF_WORD) && offset[0]) ||
           ((size == WORD) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_lane_ext.sv
// rtl/dmem_lane_ext.sv - load lane select with sign/zero extension
//
// Purpose: picks the addressed byte/half-word out of a 32-bit memory word
//          and extends it to 32 bits.
// Ports:   word     - full memory word read at acceptance
//          offset   - byte offset within the word (addr[1:0])
//          size     - access width; illegal widths produce 0
//          zero_ext - 1 = zero-extend, 0 = sign-extend
//          data     - extended load result
module dmem_lane_ext
  import data_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  ram_size_e   size,
  input  logic        zero_ext,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    // Move the addressed lane down to bit 0 so every width extracts from the bottom.
    shifted = word >> {offset, 3'b000};
    data    = '0;
    case (size)
      BYTE:      data = {{24{~zero_ext & shifted[7]}},  shifted[7:0]};
      HALF_WORD: data = {{16{~zero_ext & shifted[15]}}, shifted[15:0]};
      WORD:      data = word;
      default:   data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// rtl/data_mem.sv - single-outstanding data memory with fixed response latency
//
// Purpose: byte-addressed 32-bit word memory with valid/ready request and
//          response handshakes, byte/half/word access, alignment and range
//          faults, and a programmable acceptance-to-response latency.
// Ports:   clk_i, rst_i             - clock, synchronous active-high reset
//          req_valid_i, req_ready_o - request handshake
//          addr_i, we_i, size_i     - byte address, store/load, access width
//          unsigned_i, wdata_i      - load extension mode, store data
//          rsp_valid_o, rsp_ready_i - response handshake
//          rsp_data_o, rsp_err_o    - extended load data, fault flag
module data_mem
  import data_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  ram_size_e   size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o
);

  localparam int unsigned AW        = $clog2(MEM_WORDS);
  // Range bound kept 33 bits wide so a 4 GiB memory does not wrap to zero.
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;
  // WAIT leaves when the counter reaches this value (LATENCY-1 cycles spent in WAIT).
  localparam logic [1:0]  WAIT_LAST = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

  // Storage; contents start at zero and are never touched by reset.
  logic [31:0] mem [MEM_WORDS] = '{default: '0};

  dmem_state_e state, state_n;
  logic [1:0]  cnt, cnt_n;
  logic [31:0] data_q;
  logic        err_q;

  logic [31:0] offset;
  logic [AW-1:0] word_idx;
  logic        fault;
  logic        accept;
  logic [3:0]  be;
  logic [31:0] wlanes;
  logic [31:0] rd_word;
  logic [31:0] ext_data;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  // The subtraction wraps modulo 2^32, so addresses below BASE_ADDR land far
  // above the top of the memory and fault as out of range.
  assign offset   = addr_i - BASE_ADDR;
  assign word_idx = offset[AW+1:2];
  assign fault    = !size_legal(size_i) ||
                    size_misaligned(size_i, addr_i[1:0]) ||
                    ({1'b0, offset} >= MEM_BYTES);

  // Reset masks acceptance so a request presented during reset has no effect.
  assign accept = req_valid_i && req_ready_o && !rst_i;

  // Byte-lane enables and replicated store data so every lane sees its bytes.
  always_comb begin
    be     = 4'b0000;
    wlanes = wdata_i;
    case (size_i)
      BYTE: begin
        be     = 4'b0001 << addr_i[1:0];
        wlanes = {4{wdata_i[7:0]}};
      end
      HALF_WORD: begin
        be     = 4'b0011 << addr_i[1:0];
        wlanes = {2{wdata_i[15:0]}};
      end
      WORD: begin
        be     = 4'b1111;
        wlanes = wdata_i;
      end
      default: begin
        be     = 4'b0000;
        wlanes = wdata_i;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (accept && we_i && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[word_idx][8*b +: 8] <= wlanes[8*b +: 8];
        end
      end
    end
  end

  // Loads sample the word at acceptance; only one request is ever in flight,
  // so any earlier store has already committed by then.
  assign rd_word = mem[word_idx];

  dmem_lane_ext u_lane_ext (
    .word     (rd_word),
    .offset   (addr_i[1:0]),
    .size     (size_i),
    .zero_ext (unsigned_i),
    .data     (ext_data)
  );

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      // The response payload is frozen at acceptance and held until consumed.
      if (accept) begin
        data_q <= (we_i || fault) ? 32'h0 : ext_data;
        err_q  <= fault;
      end
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_data_o  = '0;
    rsp_err_o   = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          state_n = (LATENCY > 1) ? WAIT : RESP;
          cnt_n   = '0;
        end
      end
      WAIT: begin
        if (cnt == WAIT_LAST) begin
          state_n = RESP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 2'd1;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        rsp_data_o  = data_q;
        rsp_err_o   = err_q;
        if (rsp_ready_i) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - directed self-checking bench for data_mem
module tb_data_mem;
  import data_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v1 = 1'b0, v3 = 1'b0;
  logic        rr1 = 1'b0, rr3 = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  ram_size_e   size = WORD;
  logic        uns = 1'b0;
  logic [31:0] wdata = '0;

  logic        rdy1, rv1, re1;
  logic [31:0] rd1;
  logic        rdy3, rv3, re3;
  logic [31:0] rd3;

  int          total = 0;
  int          bad = 0;
  logic [31:0] d;
  logic        e;
  int          lat;

  always #5 clk = ~clk;

  data_mem #(.MEM_WORDS(4096), .LATENCY(1), .BASE_ADDR(32'h0)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v1), .req_ready_o(rdy1),
    .addr_i(addr), .we_i(we), .size_i(size), .unsigned_i(uns), .wdata_i(wdata),
    .rsp_valid_o(rv1), .rsp_ready_i(rr1), .rsp_data_o(rd1), .rsp_err_o(re1)
  );

  data_mem #(.MEM_WORDS(4096), .LATENCY(3), .BASE_ADDR(32'h0)) dut3 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v3), .req_ready_o(rdy3),
    .addr_i(addr), .we_i(we), .size_i(size), .unsigned_i(uns), .wdata_i(wdata),
    .rsp_valid_o(rv3), .rsp_ready_i(rr3), .rsp_data_o(rd3), .rsp_err_o(re3)
  );

  // One complete transaction on the selected instance (1 or 3), starting idle.
  // lat counts negedges after the acceptance edge until the response shows.
  task automatic xact(input int which, input logic w, input ram_size_e s, input logic u,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rdata, output logic rerr, output int rlat);
    @(negedge clk);
    addr = a; we = w; size = s; uns = u; wdata = wd;
    if (which == 1) begin v1 = 1'b1; rr1 = 1'b1; end
    else begin v3 = 1'b1; rr3 = 1'b1; end
    @(posedge clk);
    rlat = 99; rdata = 'x; rerr = 1'bx;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      v1 = 1'b0; v3 = 1'b0;
      if ((which == 1) ? rv1 : rv3) begin
        rlat  = k;
        rdata = (which == 1) ? rd1 : rd3;
        rerr  = (which == 1) ? re1 : re3;
        break;
      end
    end
    if (rlat != 99) @(posedge clk);
  endtask

  task test_reset;
    // A store presented during reset must not be accepted.
    v1 = 1'b1; we = 1'b1; size = WORD; addr = 32'h0; wdata = 32'h12345678;
    repeat (2) @(negedge clk);
    total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL reset_ready1 got=%b want=1", rdy1); end
    total++; if (rv1 !== 1'b0) begin bad++; $display("FAIL reset_valid1 got=%b want=0", rv1); end
    total++; if (rd1 !== 32'h0 || re1 !== 1'b0) begin bad++; $display("FAIL reset_rsp1 got=%h/%b want=0/0", rd1, re1); end
    total++; if (rdy3 !== 1'b1 || rv3 !== 1'b0) begin bad++; $display("FAIL reset_hs3 got=%b/%b want=1/0", rdy3, rv3); end
    rst = 1'b0; v1 = 1'b0;
    @(negedge clk);
    total++; if (rv1 !== 1'b0) begin bad++; $display("FAIL reset_no_accept got=%b want=0", rv1); end
    xact(1, 1'b0, WORD, 1'b0, 32'h0, 32'h0, d, e, lat);
    total++; if (d !== 32'h0 || e !== 1'b0) begin bad++; $display("FAIL reset_store_dropped got=%h/%b want=00000000/0", d, e); end
  endtask

  task test_word;
    xact(1, 1'b1, WORD, 1'b0, 32'h10, 32'hDEADBEEF, d, e, lat);
    total++; if (d !== 32'h0 || e !== 1'b0) begin bad++; $display("FAIL store_rsp got=%h/%b want=00000000/0", d, e); end
    total++; if (lat !== 1) begin bad++; $display("FAIL store_latency got=%0d want=1", lat); end
    xact(1, 1'b0, WORD, 1'b0, 32'h10, 32'h0, d, e, lat);
    total++; if (d !== 32'hDEADBEEF || e !== 1'b0) begin bad++; $display("FAIL load_word got=%h/%b want=deadbeef/0", d, e); end
    total++; if (lat !== 1) begin bad++; $display("FAIL load_latency got=%0d want=1", lat); end
  endtask

  task test_load_lanes;
    xact(1, 1'b0, BYTE, 1'b0, 32'h13, 32'h0, d, e, lat);
    total++; if (d !== 32'hFFFFFFDE) begin bad++; $display("FAIL byte13_signed got=%h want=ffffffde", d); end
    xact(1, 1'b0, BYTE, 1'b1, 32'h13, 32'h0, d, e, lat);
    total++; if (d !== 32'h000000DE) begin bad++; $display("FAIL byte13_unsigned got=%h want=000000de", d); end
    xact(1, 1'b0, HALF_WORD, 1'b0, 32'h12, 32'h0, d, e, lat);
    total++; if (d !== 32'hFFFFDEAD) begin bad++; $display("FAIL half12_signed got=%h want=ffffdead", d); end
    xact(1, 1'b0, HALF_WORD, 1'b1, 32'h10, 32'h0, d, e, lat);
    total++; if (d !== 32'h0000BEEF) begin bad++; $display("FAIL half10_unsigned got=%h want=0000beef", d); end
    xact(1, 1'b0, BYTE, 1'b0, 32'h10, 32'h0, d, e, lat);
    total++; if (d !== 32'hFFFFFFEF || e !== 1'b0) begin bad++; $display("FAIL byte10_signed got=%h/%b want=ffffffef/0", d, e); end
  endtask

  task test_faults;
    logic [1:0] bad_sz;
    bad_sz = 2'b11;
    xact(1, 1'b1, WORD, 1'b0, 32'h11, 32'hFFFFFFFF, d, e, lat);
    total++; if (e !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL misaligned_store got=%h/%b want=00000000/1", d, e); end
    xact(1, 1'b0, WORD, 1'b0, 32'h10, 32'h0, d, e, lat);
    total++; if (d !== 32'hDEADBEEF || e !== 1'b0) begin bad++; $display("FAIL store_fault_nowrite got=%h/%b want=deadbeef/0", d, e); end
    xact(1, 1'b0, WORD, 1'b0, 32'h4000, 32'h0, d, e, lat);
    total++; if (e !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL range_load got=%h/%b want=00000000/1", d, e); end
    xact(1, 1'b0, BYTE, 1'b1, 32'h3FFF, 32'h0, d, e, lat);
    total++; if (e !== 1'b0 || d !== 32'h0) begin bad++; $display("FAIL last_byte got=%h/%b want=00000000/0", d, e); end
    xact(1, 1'b0, HALF_WORD, 1'b0, 32'h13, 32'h0, d, e, lat);
    total++; if (e !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL misaligned_half got=%h/%b want=00000000/1", d, e); end
    xact(1, 1'b0, ram_size_e'(bad_sz), 1'b0, 32'h10, 32'h0, d, e, lat);
    total++; if (e !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL illegal_size got=%h/%b want=00000000/1", d, e); end
    xact(1, 1'b0, WORD, 1'b0, 32'hFFFFFFFC, 32'h0, d, e, lat);
    total++; if (e !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL high_addr got=%h/%b want=00000000/1", d, e); end
  endtask

  task test_store_lanes;
    xact(1, 1'b1, BYTE, 1'b0, 32'h11, 32'hFFFFFF55, d, e, lat);
    total++; if (e !== 1'b0 || d !== 32'h0) begin bad++; $display("FAIL byte_store_rsp got=%h/%b want=00000000/0", d, e); end
    xact(1, 1'b0, WORD, 1'b0, 32'h10, 32'h0, d, e, lat);
    total++; if (d !== 32'hDEAD55EF) begin bad++; $display("FAIL byte_store_merge got=%h want=dead55ef", d); end
    xact(1, 1'b1, HALF_WORD, 1'b0, 32'h12, 32'hABCD1234, d, e, lat);
    xact(1, 1'b0, WORD, 1'b0, 32'h10, 32'h0, d, e, lat);
    total++; if (d !== 32'h123455EF) begin bad++; $display("FAIL half_store_merge got=%h want=123455ef", d); end
    xact(1, 1'b0, HALF_WORD, 1'b0, 32'h10, 32'h0, d, e, lat);
    total++; if (d !== 32'h000055EF) begin bad++; $display("FAIL half10_positive got=%h want=000055ef", d); end
    xact(1, 1'b0, BYTE, 1'b0, 32'h12, 32'h0, d, e, lat);
    total++; if (d !== 32'h00000034) begin bad++; $display("FAIL byte12_signed got=%h want=00000034", d); end
  endtask

  task test_latency3;
    xact(3, 1'b1, WORD, 1'b0, 32'h40, 32'hCAFEF00D, d, e, lat);
    total++; if (lat !== 3 || e !== 1'b0) begin bad++; $display("FAIL l3_store got lat=%0d err=%b want lat=3 err=0", lat, e); end
    @(negedge clk);
    addr = 32'h40; we = 1'b0; size = WORD; uns = 1'b0; v3 = 1'b1; rr3 = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      // Present a second request while the first is still outstanding.
      if (k == 1) begin size = BYTE; uns = 1'b1; end
      total++; if (rv3 !== (k >= 3)) begin bad++; $display("FAIL l3_valid_k%0d got=%b want=%b", k, rv3, (k >= 3)); end
      total++; if (rdy3 !== 1'b0) begin bad++; $display("FAIL l3_ready_k%0d got=%b want=0", k, rdy3); end
      if (k >= 3) begin
        total++; if (rd3 !== 32'hCAFEF00D || re3 !== 1'b0) begin bad++; $display("FAIL l3_hold_k%0d got=%h/%b want=cafef00d/0", k, rd3, re3); end
      end
      if (k == 7) rr3 = 1'b1;
    end
    @(negedge clk);
    total++; if (rdy3 !== 1'b1 || rv3 !== 1'b0) begin bad++; $display("FAIL l3_release got=%b/%b want=1/0", rdy3, rv3); end
    @(posedge clk);
    lat = 99; d = 'x;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      v3 = 1'b0;
      if (rv3) begin lat = k; d = rd3; break; end
    end
    if (lat != 99) @(posedge clk);
    total++; if (lat !== 3 || d !== 32'h0000000D) begin bad++; $display("FAIL l3_second got lat=%0d data=%h want lat=3 data=0000000d", lat, d); end
  endtask

  task test_reset_wait;
    @(negedge clk);
    addr = 32'h20; we = 1'b1; size = BYTE; uns = 1'b0; wdata = 32'h000000AA; v3 = 1'b1; rr3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v3 = 1'b0;
    total++; if (rdy3 !== 1'b0) begin bad++; $display("FAIL rw_in_wait got=%b want=0", rdy3); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (rdy3 !== 1'b1 || rv3 !== 1'b0) begin bad++; $display("FAIL rw_after_reset got=%b/%b want=1/0", rdy3, rv3); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (rv3 !== 1'b0) begin bad++; $display("FAIL rw_dropped_k%0d got=%b want=0", k, rv3); end
    end
    xact(3, 1'b0, BYTE, 1'b1, 32'h20, 32'h0, d, e, lat);
    total++; if (d !== 32'h000000AA || e !== 1'b0 || lat !== 3) begin bad++; $display("FAIL rw_committed got=%h/%b lat=%0d want=000000aa/0 lat=3", d, e, lat); end
    xact(1, 1'b0, WORD, 1'b0, 32'h10, 32'h0, d, e, lat);
    total++; if (d !== 32'h123455EF) begin bad++; $display("FAIL rw_mem_kept got=%h want=123455ef", d); end
  endtask

  initial begin
    test_reset;
    test_word;
    test_load_lanes;
    test_faults;
    test_store_lanes;
    test_latency3;
    test_reset_wait;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 4096, capacity in 32-bit words (power of two).
REQ-002 SHALL have parameter LATENCY, default 1, acceptance-to-response cycles, legal range 1..4.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0, byte address of word 0.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid_i  input  1  request present.
REQ-007 SHALL have port req_ready_o  output  1  request can be accepted.
REQ-008 SHALL have port addr_i  input  32  byte address.
REQ-009 SHALL have port we_i  input  1  1 = store, 0 = load.
REQ-010 SHALL have port size_i  input  ram_size_e  BYTE / HALF_WORD / WORD.
REQ-011 SHALL have port unsigned_i  input  1  zero-extend load when 1, else sign-extend.
REQ-012 SHALL have port wdata_i  input  32  store data, low bytes significant.
REQ-013 SHALL have port rsp_valid_o  output  1  response present.
REQ-014 SHALL have port rsp_ready_i  input  1  consumer takes response.
REQ-015 SHALL have port rsp_data_o  output  32  extended load data; 0 for stores and errors.
REQ-016 SHALL have port rsp_err_o  output  1  access faulted (misaligned or out of range).

Function
REQ-017 Acceptance SHALL occur on a rising edge where req_valid_i && req_ready_o; request inputs sampled only then.
REQ-018 FSM SHALL have states IDLE, WAIT, RESP; req_ready_o = 1 only in IDLE; one request outstanding.
REQ-019 IDLE -> WAIT on acceptance when LATENCY > 1, else IDLE -> RESP; WAIT counts LATENCY-1 cycles, then -> RESP.
REQ-020 RESP SHALL assert rsp_valid_o with rsp_data_o/rsp_err_o held stable until the edge with rsp_ready_i = 1, then -> IDLE.
REQ-021 rsp_valid_o SHALL first be high exactly LATENCY cycles after the acceptance edge.
REQ-022 Fault SHALL be raised when HALF_WORD with addr[0] = 1, WORD with addr[1:0] != 0, or (addr - BASE_ADDR) >= 4*MEM_WORDS (32-bit unsigned wrap).
REQ-023 Faulted stores SHALL modify no memory; faulted loads SHALL return rsp_data_o = 0, rsp_err_o = 1.
REQ-024 Non-faulting store SHALL write only the addressed byte lanes (1, 2 or 4) at the acceptance edge; other lanes unchanged.
REQ-025 Non-faulting load SHALL read the word at the acceptance edge, select lanes by addr[1:0], extend per unsigned_i; ram_size_e values outside BYTE/HALF_WORD/WORD SHALL fault.
REQ-026 A load accepted after a store SHALL observe the stored data (no stale read).
REQ-027 Store response SHALL carry rsp_data_o = 0, rsp_err_o = 0 when non-faulting.
REQ-028 Memory contents SHALL initialise to zero at time 0.

Reset
REQ-029 rst_i high at an edge SHALL force IDLE, counter 0, rsp_valid_o = 0, rsp_data_o = 0, rsp_err_o = 0, req_ready_o = 1 after that edge.
REQ-030 Reset SHALL NOT clear memory contents; a store accepted before reset stays committed.
REQ-031 Reset during WAIT or RESP SHALL drop the outstanding response without emitting it.
REQ-032 req_valid_i during a reset cycle SHALL NOT be accepted.

Structure
REQ-033 ram_size_e SHALL remain in the shared package types; dmem_state_e (IDLE, WAIT, RESP) SHALL be added there.
REQ-034 Lane select and sign/zero extension SHALL live in sub-module dmem_lane_ext (combinational, word + offset + size + unsigned in, 32-bit out).
REQ-035 Storage SHALL be a word array of MEM_WORDS x 32 bits with per-byte write enable.

Verification
REQ-036 LATENCY=1: store WORD 32'hDEADBEEF @0x10, then load WORD @0x10 -> rsp_data_o = 32'hDEADBEEF, rsp_valid_o one cycle after acceptance.
REQ-037 After REQ-036: load BYTE @0x13 signed -> 32'hFFFFFFDE; unsigned -> 32'h000000DE; load HALF_WORD @0x12 signed -> 32'hFFFFDEAD.
REQ-038 Store WORD @0x11 -> rsp_err_o = 1, word @0x10 still 32'hDEADBEEF; load @4*MEM_WORDS -> rsp_err_o = 1, data 0.
REQ-039 LATENCY=3, rsp_ready_i held 0 for 5 cycles -> rsp_valid_o high from cycle 3, data stable, req_ready_o = 0 throughout; second request accepted only after release.
REQ-040 rst_i asserted in WAIT after store BYTE 8'hAA @0x20 -> no response, req_ready_o = 1 next cycle, subsequent load BYTE @0x20 unsigned -> 32'h000000AA.
